// File: rtl/regfile_debug_port.sv
// Debug access controller for the 4 x 8-bit register file.
// Halts the CPU, then reads, writes or dumps registers on host command.
module regfile_debug_port #(
  parameter logic [7:0] ACK_BYTE = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd_data,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       halt_req,
  input  logic       halt_ack,
  output logic [1:0] dbg_readreg,
  input  logic [7:0] dbg_read,
  output logic [1:0] dbg_writereg,
  output logic [7:0] dbg_data,
  output logic       dbg_regwrite
);

  typedef enum logic [2:0] {
    IDLE,
    GETDATA,
    HALT,
    WR,
    RD,
    RESP
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  state_t     state_q, state_d;
  logic [1:0] op_q, op_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [1:0] dump_q, dump_d;
  logic [7:0] rsp_q, rsp_d;

  logic cmd_fire;
  logic rsp_fire;

  // Moore-style outputs decoded from registered state and operands.
  always_comb begin
    cmd_ready    = ~rst & ((state_q == IDLE) | (state_q == GETDATA));
    rsp_valid    = (state_q == RESP);
    halt_req     = (state_q == HALT) | (state_q == WR)
                 | (state_q == RD)   | (state_q == RESP);
    dbg_regwrite = (state_q == WR);
    dbg_readreg  = (op_q == OP_DUMP) ? dump_q : idx_q;
    dbg_writereg = idx_q;
    dbg_data     = data_q;
    rsp_data     = rsp_q;
  end

  assign cmd_fire = cmd_valid & cmd_ready;
  assign rsp_fire = rsp_valid & rsp_ready;

  // Next-state and operand update logic.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    data_d  = data_q;
    dump_d  = dump_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          op_d  = cmd_data[7:6];
          idx_d = cmd_data[1:0];
          if (cmd_data[7:6] == OP_WRITE) begin
            state_d = GETDATA;
          end else if (cmd_data[7:6] != OP_NOP) begin
            state_d = HALT;
            if (cmd_data[7:6] == OP_DUMP) dump_d = 2'd0;
          end
        end
      end
      GETDATA: begin
        if (cmd_fire) begin
          data_d  = cmd_data;
          state_d = HALT;
        end
      end
      HALT: begin
        if (halt_ack) state_d = (op_q == OP_WRITE) ? WR : RD;
      end
      WR: begin
        rsp_d   = ACK_BYTE;
        state_d = RESP;
      end
      RD: begin
        rsp_d   = dbg_read;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_fire) begin
          if ((op_q == OP_DUMP) && (dump_q != 2'd3)) begin
            dump_d  = dump_q + 2'd1;
            state_d = RD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      idx_q   <= 2'd0;
      data_q  <= 8'd0;
      dump_q  <= 2'd0;
      rsp_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      dump_q  <= dump_d;
      rsp_q   <= rsp_d;
    end
  end

endmodule

// File: tb/tb_regfile_debug_port.sv
// Scoreboard bench for regfile_debug_port.
// Register file modelled here; monitor checks writes and responses.
module tb_regfile_debug_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] rsp_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       halt_req;
  logic       halt_ack;
  logic [1:0] dbg_readreg;
  logic [7:0] dbg_read;
  logic [1:0] dbg_writereg;
  logic [7:0] dbg_data;
  logic       dbg_regwrite;

  int errors = 0;
  int checks = 0;
  int wr_count = 0;
  int rsp_count = 0;
  bit chk_halt = 0;

  logic [7:0] rf [4];
  logic [7:0] rq [$];
  logic [9:0] wq [$];

  regfile_debug_port #(.ACK_BYTE(8'hA5)) dut (
    .clk(clk),
    .rst(rst),
    .cmd_data(cmd_data),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .rsp_data(rsp_data),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .halt_req(halt_req),
    .halt_ack(halt_ack),
    .dbg_readreg(dbg_readreg),
    .dbg_read(dbg_read),
    .dbg_writereg(dbg_writereg),
    .dbg_data(dbg_data),
    .dbg_regwrite(dbg_regwrite)
  );

  always #5 clk = ~clk;

  assign dbg_read = rf[dbg_readreg];

  always @(posedge clk) begin
    if (dbg_regwrite) rf[dbg_writereg] <= dbg_data;
  end

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got timeout/unexpected expected event", nm);
  endtask

  // Monitor: handshakes complete at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dbg_regwrite) begin
        wr_count++;
        if (wq.size() == 0) bad("unexpected_write");
        else begin
          chk("wr_reg", 16'(dbg_writereg), 16'(wq[0][9:8]));
          chk("wr_data", 16'(dbg_data), 16'(wq[0][7:0]));
          void'(wq.pop_front());
        end
      end
      if (rsp_valid) begin
        if (rq.size() == 0) bad("unexpected_rsp");
        else if (rsp_ready) begin
          chk("rsp", 16'(rsp_data), 16'(rq[0]));
          void'(rq.pop_front());
          rsp_count++;
        end else begin
          chk("rsp_hold", 16'(rsp_data), 16'(rq[0]));
        end
      end
      if (chk_halt) chk("halt_cont", 16'(halt_req), 16'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    cmd_valid = 1'b1;
    cmd_data  = b;
    n = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) bad("cmd_timeout");
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input int cnt, input int stall);
    int n;
    for (int i = 0; i < cnt; i++) begin
      n = 0;
      while (!rsp_valid && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) bad("rsp_timeout");
      for (int s = 0; s < stall; s++) tick();
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
  endtask

  task automatic settle_empty();
    tick();
    tick();
    chk("rq_empty", 16'(rq.size()), 16'd0);
    chk("wq_empty", 16'(wq.size()), 16'd0);
  endtask

  int wc0;
  int n0;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_data  = 8'h43;
    rsp_ready = 1'b0;
    halt_ack  = 1'b1;
    for (int i = 0; i < 4; i++) rf[i] = 8'h00;
    tick();
    tick();
    @(negedge clk);
    chk("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    chk("rst_halt_req", 16'(halt_req), 16'd0);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_regwrite", 16'(dbg_regwrite), 16'd0);
    chk("rst_rsp_data", 16'(rsp_data), 16'd0);
    chk("rst_dbg_data", 16'(dbg_data), 16'd0);
    tick();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_ready", 16'(cmd_ready), 16'd1);
    tick();
    tick();
    chk("post_rst_halt", 16'(halt_req), 16'd0);
    chk("post_rst_rsp", 16'(rsp_valid), 16'd0);

    // WRITE r2 = 0x3C
    wq.push_back({2'd2, 8'h3C});
    rq.push_back(8'hA5);
    send(8'h82);
    chk("getdata_nohalt", 16'(halt_req), 16'd0);
    send(8'h3C);
    n0 = 0;
    while (!halt_req && n0 < 20) begin
      tick();
      n0++;
    end
    chk("wr_halt_rise", 16'(halt_req), 16'd1);
    get_rsp(1, 0);
    chk("wr_halt_drop", 16'(halt_req), 16'd0);
    chk("wr_rf2", 16'(rf[2]), 16'h3C);
    chk("wr_count", 16'(wr_count), 16'd1);
    settle_empty();

    // READ r1 with delayed halt_ack
    rf[0] = 8'hE0;
    rf[1] = 8'h5A;
    rf[3] = 8'hE3;
    halt_ack = 1'b0;
    wc0 = wr_count;
    rq.push_back(8'h5A);
    send(8'h41);
    for (int i = 0; i < 5; i++) begin
      chk("halt_wait_req", 16'(halt_req), 16'd1);
      chk("halt_wait_rsp", 16'(rsp_valid), 16'd0);
      tick();
    end
    halt_ack = 1'b1;
    n0 = 0;
    while (!rsp_valid && n0 < 20) begin
      tick();
      n0++;
    end
    chk("rd_readreg", 16'(dbg_readreg), 16'd1);
    get_rsp(1, 2);
    chk("rd_no_write", 16'(wr_count), 16'(wc0));
    settle_empty();

    // DUMP with stalls, halt must stay high
    rf[0] = 8'h11;
    rf[1] = 8'h22;
    rf[2] = 8'h33;
    rf[3] = 8'h44;
    rq.push_back(8'h11);
    rq.push_back(8'h22);
    rq.push_back(8'h33);
    rq.push_back(8'h44);
    n0 = rsp_count;
    send(8'hC0);
    tick();
    chk_halt = 1;
    get_rsp(4, 1);
    chk_halt = 0;
    chk("dump_count", 16'(rsp_count - n0), 16'd4);
    tick();
    chk("dump_halt_drop", 16'(halt_req), 16'd0);
    settle_empty();

    // NOP then READ r3 (ignored bits set)
    send(8'h00);
    for (int i = 0; i < 4; i++) tick();
    chk("nop_no_rsp", 16'(rsp_valid), 16'd0);
    chk("nop_no_halt", 16'(halt_req), 16'd0);
    rq.push_back(8'h44);
    send(8'h7F);
    get_rsp(1, 0);
    settle_empty();

    // Reset during third DUMP response
    rq.push_back(8'h11);
    rq.push_back(8'h22);
    send(8'hC0);
    get_rsp(2, 0);
    n0 = 0;
    while (!rsp_valid && n0 < 20) begin
      tick();
      n0++;
    end
    chk("abort_pending", 16'(rsp_valid), 16'd1);
    rq.push_back(8'h33);
    rst = 1'b1;
    #1;
    chk("abort_rsp_drop", 16'(rsp_valid), 16'd0);
    chk("abort_halt_drop", 16'(halt_req), 16'd0);
    rq.delete();
    tick();
    rst = 1'b0;
    tick();
    rq.push_back(8'h33);
    send(8'h42);
    get_rsp(1, 0);
    settle_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
